// File: rtl/run_controller.sv
// Upstream sequencer for the 9-bit core: loads a program image into imem, pulses start, counts run cycles to halt.
// Optional run-cycle limit enabled by defining RUN_CTRL_TIMEOUT_EN.
module run_controller #(
  parameter int unsigned INSTR_WIDTH    = 9,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned START_CYCLES   = 2,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 'hFFF0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic                   load_valid,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_last,
  output logic                   load_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_start,
  input  logic                   cpu_halt,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   timeout,
  output logic [ADDR_WIDTH:0]    prog_len,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned SC_W  = (START_CYCLES < 2) ? 1 : $clog2(START_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [SC_W-1:0]       SC_LAST   = SC_W'(START_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     prog_len_q, prog_len_d;
  logic [SC_W-1:0]      sc_q, sc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 to_q, to_d;
  logic                 hs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      prog_len_q <= '0;
      sc_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_len_q <= prog_len_d;
      sc_q       <= sc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      to_q       <= to_d;
    end
  end

  // The write pointer is the low bits of prog_len; the extra bit lets it report a full memory.
  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    sc_d       = sc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    to_d       = to_q;
    load_ready = 1'b0;
    hs         = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d    = S_LOAD;
          prog_len_d = '0;
          ovf_d      = 1'b0;
          to_d       = 1'b0;
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        hs         = load_valid;
        if (hs) begin
          imem_we    = 1'b1;
          imem_addr  = prog_len_q[ADDR_WIDTH-1:0];
          imem_wdata = load_data;
          prog_len_d = prog_len_q + LEN_W'(1);
          if (load_last || prog_len_q[ADDR_WIDTH-1:0] == LAST_ADDR) begin
            state_d = S_START;
            sc_d    = '0;
            cnt_d   = '0;
            ovf_d   = !load_last;
          end
        end
      end
      S_START: begin
        sc_d = sc_q + SC_W'(1);
        if (sc_q == SC_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (cpu_halt) begin
          state_d = S_DONE;
`ifdef RUN_CTRL_TIMEOUT_EN
        end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
          state_d = S_DONE;
          to_d    = 1'b1;
`endif
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_DONE: begin
        if (!go) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cpu_start   = (state_q == S_START);
  assign busy        = (state_q == S_LOAD) || (state_q == S_START) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign overflow    = ovf_q;
`ifdef RUN_CTRL_TIMEOUT_EN
  assign timeout     = to_q;
`else
  assign timeout     = 1'b0;
`endif
  assign prog_len    = prog_len_q;
  assign cycle_count = cnt_q;

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Upstream sequencer for the 9-bit CPU core.
- Streams a program image into instruction memory over a valid/ready interface.
- Pulses the core's `start`, then counts executed cycles until the core raises `halt`.
- Reports completion, cycle count and overflow status to the bench or host side.

Parameters:
- INSTR_WIDTH, 9, instruction word width written to instruction memory.
- ADDR_WIDTH, 8, instruction memory address width (depth 2^ADDR_WIDTH).
- START_CYCLES, 2, number of cycles `cpu_start` is held high (minimum 1).
- CNT_WIDTH, 16, width of the run-cycle counter.
- TIMEOUT_CYCLES, 16'hFFF0, run-cycle limit; used only when RUN_CTRL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- go  in  1  level request: begin load+run; sampled in IDLE and DONE.
- load_valid  in  1  program word valid.
- load_data  in  INSTR_WIDTH  program word.
- load_last  in  1  marks final program word.
- load_ready  out  1  controller accepts a word this cycle.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_WIDTH  instruction memory write address.
- imem_wdata  out  INSTR_WIDTH  instruction memory write data.
- cpu_start  out  1  drives core `start` (core resets PC and counters while high).
- cpu_halt  in  1  core `halt` output.
- busy  out  1  high in LOAD/START/RUN.
- done  out  1  high in DONE.
- overflow  out  1  program exceeded memory depth (sticky until next load).
- timeout  out  1  run terminated by limit (sticky until next load).
- prog_len  out  ADDR_WIDTH+1  number of words accepted in last load.
- cycle_count  out  CNT_WIDTH  run cycles counted.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. All outputs 0, except `prog_len` and `cycle_count`, which also clear to 0. Reset asserted mid-operation aborts immediately; words already written stay in memory.
- States: IDLE, LOAD, START, RUN, DONE.
- IDLE:
  - `load_ready`=0.
  - If go=1 -> LOAD: clear write pointer, `prog_len`, `overflow`, `timeout`.
- LOAD:
  - `load_ready`=1.
  - On a handshake (load_valid & load_ready):
    - Combinationally, in the same cycle: `imem_we`=1, `imem_addr`=pointer, `imem_wdata`=load_data.
    - At the edge: pointer+1, `prog_len`+1.
  - `go` is ignored in this state.
  - If the handshake has load_last=1 -> START.
  - If the accepted word is at address 2^ADDR_WIDTH-1 without load_last: treat it as last, set `overflow`=1, go to START. The pointer never wraps.
  - load_valid=0 holds in LOAD indefinitely.
- START:
  - `cpu_start`=1 for exactly START_CYCLES consecutive cycles.
  - `cycle_count` cleared on entry.
  - Then -> RUN.
  - `cpu_halt` is ignored during START.
- RUN:
  - `cpu_start`=0.
  - Each cycle with cpu_halt=0: `cycle_count`+1, saturating at all-ones (no wrap).
  - First cycle with cpu_halt=1 -> DONE; that cycle is not counted, and `cycle_count` is frozen.
  - A halt on the first RUN cycle yields `cycle_count`=0.
- DONE:
  - `done`=1; `cycle_count` and `prog_len` hold.
  - go=0 -> IDLE.
  - go held high stays in DONE (no automatic rerun); the host must drop and re-raise go.
- `busy` is 1 exactly in LOAD, START and RUN. `busy` and `done` are never both 1.
- All state, counter and flag updates are registered; only the imem_* outputs and `load_ready` are decoded from the current state.

Optional Feature:
- Macro RUN_CTRL_TIMEOUT_EN.
- Defined: in RUN, when `cycle_count` reaches TIMEOUT_CYCLES with cpu_halt still 0, go to DONE next edge with `timeout`=1 and `cycle_count`=TIMEOUT_CYCLES. If cpu_halt=1 in that same cycle, halt wins and `timeout` stays 0.
- Not defined:
  - `timeout` tied 0.
  - RUN waits for halt indefinitely.
  - Counter saturates.

Test Plan:
- Load 3 words (0x1A5, 0x0F0, 0x1FF; last on third) with go=1 -> addresses 0,1,2 written in order, `prog_len`=3, then `cpu_start` high exactly 2 cycles.
- cpu_halt rises 10 cycles after `cpu_start` falls -> DONE with `cycle_count`=10, `busy`=0, `done`=1. Dropping go -> IDLE.
- load_valid toggled 1,0,1,0 during LOAD -> only valid cycles write, addresses stay contiguous, no duplicate or skipped address.
- ADDR_WIDTH=4, 20 words with no last -> 16 words written (addr 0..15), `overflow`=1, `prog_len`=16, controller proceeds to START.
- rst_n=0 for one cycle mid-RUN (`cycle_count`=5) -> next cycle IDLE, `cycle_count`=0, `cpu_start`=0, `busy`=0.
- With RUN_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=8 and halt never raised -> DONE with `timeout`=1, `cycle_count`=8. Without the macro, still RUN after 100 cycles with `cycle_count`=100.
